// File: rtl/spi_ram_pkg.sv
// Shared definitions for the command-decoded burst RAM behind the SPI slave.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: command codes, controller state type, even-parity helper.
// Optional feature macro used by the RAM files: SPI_RAM_PARITY_EN.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WDATA = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;
  localparam logic [1:0] CMD_RDATA = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Widest word the parity helper accepts; callers zero-extend, which leaves
  // the XOR reduction unchanged.
  localparam int PAR_MAX_W = 64;

  // Even parity bit: the stored word plus this bit always holds an even number of ones.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port storage array: synchronous write, combinational read.
// Latency: write lands at the clock edge; read data is valid in the same cycle as raddr.
// Backpressure: none; the controller owns all sequencing.
// Ports: clk, we/waddr/wdata (write side), raddr/rdata/rerr (read side).
// SPI_RAM_PARITY_EN: store an extra even-parity bit per word and report a
// mismatch on rerr; otherwise rerr is constant 0.
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef SPI_RAM_PARITY_EN
  // Bit DATA_W holds the parity of bits [DATA_W-1:0].
  logic [DATA_W:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= {even_parity(PAR_MAX_W'(wdata)), wdata};
  end

  assign rdata = mem[raddr][DATA_W-1:0];
  // Any odd number of ones across data+parity means the word was corrupted.
  assign rerr  = ^mem[raddr];
`else
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
  assign rerr  = 1'b0;
`endif

endmodule

// File: rtl/spi_ram_burst.sv
// Command-decoded RAM with auto-incrementing addresses and burst reads up to 2**BURST_W words.
// Latency: read data and tx_valid appear the cycle after the read command or the accepting handshake.
// Backpressure: dout/tx_valid hold while tx_ready=0; commands arriving during a burst are dropped (rx_drop).
// Ports: clk, rstn; din/rx_valid command input with rx_busy/rx_drop status;
//        dout/tx_valid/tx_ready read stream; par_err flags a parity fault on dout.
// Optional feature macro: SPI_RAM_PARITY_EN (parity-protected storage; par_err is 0 without it).
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,   // must be <= DATA_W
  parameter int BURST_W = 4    // must be <= DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic              rx_busy,
  output logic              rx_drop,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              par_err
);

  logic [1:0]         cmd;
  logic [DATA_W-1:0]  payload;
  state_t             state;
  logic [ADDR_W-1:0]  write_addr;
  logic [ADDR_W-1:0]  read_addr;
  logic [BURST_W-1:0] remaining;   // words still to fetch after the one on dout
  logic               mem_we;
  logic [DATA_W-1:0]  mem_rdata;
  logic               mem_rerr;

  assign cmd     = din[DATA_W+1:DATA_W];
  assign payload = din[DATA_W-1:0];
  assign rx_busy = (state == SEND);

  // Writes are only legal while idle, so reads and writes never overlap.
  assign mem_we = (state == IDLE) && rx_valid && (cmd == CMD_WDATA);

  spi_ram_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (write_addr),
    .wdata (payload),
    .raddr (read_addr),
    .rdata (mem_rdata),
    .rerr  (mem_rerr)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      write_addr <= '0;
      read_addr  <= '0;
      remaining  <= '0;
      dout       <= '0;
      tx_valid   <= 1'b0;
      rx_drop    <= 1'b0;
      par_err    <= 1'b0;
    end else begin
      // Any command seen during SEND, including the final-handshake cycle, is discarded.
      rx_drop <= rx_valid && (state == SEND);

      case (state)
        IDLE: begin
          if (rx_valid) begin
            case (cmd)
              CMD_WADDR: write_addr <= payload[ADDR_W-1:0];
              CMD_WDATA: write_addr <= write_addr + 1'b1;
              CMD_RADDR: read_addr  <= payload[ADDR_W-1:0];
              default: begin
                dout      <= mem_rdata;
                par_err   <= mem_rerr;
                tx_valid  <= 1'b1;
                read_addr <= read_addr + 1'b1;
                remaining <= payload[BURST_W-1:0];
                state     <= SEND;
              end
            endcase
          end
        end

        SEND: begin
          if (tx_valid && tx_ready) begin
            if (remaining != '0) begin
              dout      <= mem_rdata;
              par_err   <= mem_rerr;
              read_addr <= read_addr + 1'b1;
              remaining <= remaining - 1'b1;
            end else begin
              tx_valid <= 1'b0;
              par_err  <= 1'b0;
              state    <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Self-checking bench for spi_ram_burst: a reference memory/address model predicts each
// read word, a monitor compares every presented word against the expected queue.
// Covers reset values, hold under backpressure, address wrap, dropped commands,
// reset mid-burst, parity faults (with SPI_RAM_PARITY_EN), and a randomized command mix.
module tb_spi_ram_burst;

  logic       clk;
  logic       rstn;
  logic [9:0] din;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_drop;
  logic [7:0] dout;
  logic       tx_valid;
  logic       tx_ready;
  logic       par_err;

  spi_ram_burst dut (
    .clk      (clk),
    .rstn     (rstn),
    .din      (din),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .rx_drop  (rx_drop),
    .dout     (dout),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .par_err  (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] ref_mem [256];
  bit         ref_perr [256];
  logic [7:0] ref_waddr;
  logic [7:0] ref_raddr;
  logic [8:0] exp_q [$];   // {par_err, dout} of each word still to be delivered

  int checks     = 0;
  int failures   = 0;
  int exp_drops  = 0;
  int drop_seen  = 0;
  int rdy_mode   = 0;      // 0: tx_ready low, 1: high, 2: random per cycle

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       tx_ready = 1'b0;
      1:       tx_ready = 1'b1;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Present one command for one edge and update the model. A burst still owed
  // to the consumer at that edge means the DUT is busy and must drop it.
  task automatic send_cmd(input logic [1:0] c, input logic [7:0] p);
    logic busy;
    tick();
    busy     = (exp_q.size() != 0);
    din      = {c, p};
    rx_valid = 1'b1;
    if (busy) begin
      exp_drops++;
    end else begin
      case (c)
        2'b00: ref_waddr = p;
        2'b01: begin
          ref_mem[ref_waddr]  = p;
          ref_perr[ref_waddr] = 1'b0;
          ref_waddr++;
        end
        2'b10: ref_raddr = p;
        default: begin
          for (int i = 0; i <= int'(p[3:0]); i++) begin
            exp_q.push_back({ref_perr[ref_raddr], ref_mem[ref_raddr]});
            ref_raddr++;
          end
        end
      endcase
    end
    tick();
    rx_valid = 1'b0;
    if (!busy && c == 2'b11) begin
      chk("rd_latency_tx_valid", tx_valid, 1);
      chk("rd_latency_rx_busy", rx_busy, 1);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < 500) begin
      tick();
      n++;
    end
    chk({name, "_completes"}, n < 500, 1);
    chk({name, "_rx_busy_low"}, rx_busy, 0);
  endtask

  // Monitor: compares every presented word, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (rx_drop) drop_seen++;
        if (tx_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_tx_valid", 1, 0);
          end else begin
            chk("dout", dout, exp_q[0][7:0]);
            chk("par_err", par_err, exp_q[0][8]);
            if (tx_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn     = 1'b0;
    din      = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    ref_waddr = '0;
    ref_raddr = '0;
    for (int i = 0; i < 256; i++) ref_perr[i] = 1'b0;
    #12;
    chk("reset_dout", dout, 0);
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_rx_busy", rx_busy, 0);
    chk("reset_rx_drop", rx_drop, 0);
    chk("reset_par_err", par_err, 0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Give the whole memory known contents.
    send_cmd(2'b00, 8'h00);
    for (int i = 0; i < 256; i++) send_cmd(2'b01, 8'($urandom));

    // Test 1: write path
    send_cmd(2'b00, 8'h10);
    send_cmd(2'b01, 8'hAA);
    send_cmd(2'b01, 8'hBB);
    chk("t1_write_addr", dut.write_addr, 8'h12);
    chk("t1_dout_idle", dout, 0);
    chk("t1_tx_valid_idle", tx_valid, 0);

    // Test 2: single read held under backpressure
    rdy_mode = 0;
    send_cmd(2'b10, 8'h10);
    send_cmd(2'b11, 8'h00);
    repeat (2) begin
      tick();
      chk("t2_hold_tx_valid", tx_valid, 1);
    end
    rdy_mode = 1;
    tick();
    chk("t2_hold_tx_valid", tx_valid, 1);
    tick();
    chk("t2_tx_valid_dropped", tx_valid, 0);
    chk("t2_rx_busy_low", rx_busy, 0);
    chk("t2_queue_drained", exp_q.size(), 0);

    // Test 3: address wrap on write and read
    send_cmd(2'b00, 8'hFE);
    send_cmd(2'b01, 8'h01);
    send_cmd(2'b01, 8'h02);
    send_cmd(2'b01, 8'h03);
    send_cmd(2'b10, 8'hFE);
    rdy_mode = 1;
    send_cmd(2'b11, 8'h02);
    n = 0;
    while (tx_valid && n < 50) begin
      tick();
      n++;
    end
    chk("t3_burst_cycles", n, 3);
    chk("t3_read_addr", dut.read_addr, 8'h01);
    chk("t3_write_addr", dut.write_addr, 8'h01);

    // Test 4: command during a burst is dropped
    send_cmd(2'b00, 8'h20);
    send_cmd(2'b01, 8'h77);
    send_cmd(2'b00, 8'h20);
    rdy_mode = 0;
    send_cmd(2'b10, 8'h50);
    send_cmd(2'b11, 8'h03);
    send_cmd(2'b01, 8'h55);
    rdy_mode = 2;
    wait_idle("t4_burst");
    tick();
    chk("t4_drop_count", drop_seen, exp_drops);
    chk("t4_write_addr", dut.write_addr, 8'h20);
    chk("t4_read_addr", dut.read_addr, 8'h54);
    rdy_mode = 1;
    send_cmd(2'b10, 8'h20);
    send_cmd(2'b11, 8'h00);
    wait_idle("t4_readback");

    // Test 5: reset in the middle of a 4-word burst
    rdy_mode = 0;
    send_cmd(2'b10, 8'h30);
    send_cmd(2'b11, 8'h03);
    rdy_mode = 1;
    tick();
    tick();
    rstn = 1'b0;
    #1;
    chk("t5_tx_valid", tx_valid, 0);
    chk("t5_dout", dout, 0);
    chk("t5_rx_busy", rx_busy, 0);
    chk("t5_par_err", par_err, 0);
    exp_q.delete();
    ref_raddr = '0;
    ref_waddr = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    send_cmd(2'b11, 8'h01);
    wait_idle("t5_after_reset");

`ifdef SPI_RAM_PARITY_EN
    // Test 6: corrupted stored word reports a parity error
    send_cmd(2'b00, 8'h40);
    send_cmd(2'b01, 8'h0F);
    send_cmd(2'b01, 8'h3C);
    dut.u_mem.mem[8'h40][0] = ~dut.u_mem.mem[8'h40][0];
    ref_mem[8'h40]  = 8'h0E;
    ref_perr[8'h40] = 1'b1;
    rdy_mode = 1;
    send_cmd(2'b10, 8'h40);
    send_cmd(2'b11, 8'h01);
    wait_idle("t6_parity");
`endif

    // Randomized command mix with random backpressure
    rdy_mode = 2;
    for (int k = 0; k < 400; k++) begin
      send_cmd(2'($urandom_range(0, 3)), 8'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle("rand_end");
    tick();
    tick();
    chk("rand_drop_count", drop_seen, exp_drops);
    chk("rand_write_addr", dut.write_addr, ref_waddr);
    chk("rand_read_addr", dut.read_addr, ref_raddr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
